elevator_car_controller: RTL and testbench

- Service-side controller for the 4-floor elevator.
- Consumes the latched indoor request vector and moves the car one floor at a time, using SCAN ordering.
- Opens the door on arrival at a requested floor.
- Drives back current_floor and opnd; the request latch uses these to clear serviced requests, closing the request/service loop.

---
 rtl/elevator_car_controller.sv | 175 +++++++++++++++++
 tb/tb_elevator_car_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_controller.sv
// elevator_car_controller
//   Service-side controller for a 4-floor elevator car. It takes the latched
//   indoor request vector and moves the car one floor at a time in SCAN order.
//   The door opens when the car arrives at a requested floor. current_floor and
//   opnd feed back to the request latch so that it can clear served requests.
//
// Parameters
//   FLOOR_TICKS : clock cycles to travel one floor (>= 2)
//   DOOR_TICKS  : clock cycles the door stays open (>= 1)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active low
//   request_seq   in   [3:0] pending requests, bit i = floor i (level)
//   current_floor out  [1:0] car position 0..3
//   opnd          out  door open, high for the whole door-open period
//   moving        out  high while travelling up or down
//   dir_up        out  current or last travel direction, 1 = up
//   arrive        out  one-cycle pulse on each floor change
module elevator_car_controller #(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] request_seq,
  output logic [1:0] current_floor,
  output logic       opnd,
  output logic       moving,
  output logic       dir_up,
  output logic       arrive
);

  localparam int FW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [FW-1:0] FLOOR_LAST = FW'(FLOOR_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST  = DW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      floor_reg, floor_next;
  logic            opnd_reg, opnd_next;
  logic            moving_reg, moving_next;
  logic            dir_reg, dir_next;
  logic            arrive_reg, arrive_next;
  logic [FW-1:0]   tick_reg, tick_next;
  logic [DW-1:0]   door_reg, door_next;

  // Floor the car reaches at the end of the current segment. Only meaningful
  // in the move states, where the bounds guarantee no wrap.
  logic [1:0]      arrive_floor;
  assign arrive_floor = (state_reg == MOVE_DOWN) ? (floor_reg - 2'd1) : (floor_reg + 2'd1);

  // Request masks relative to the present floor (IDLE decisions) and to the
  // floor about to be reached (arrival decisions).
  logic [3:0] above_cur, below_cur, above_new, below_new;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_masks
      assign above_cur[gi] = request_seq[gi] & (2'(gi) > floor_reg);
      assign below_cur[gi] = request_seq[gi] & (2'(gi) < floor_reg);
      assign above_new[gi] = request_seq[gi] & (2'(gi) > arrive_floor);
      assign below_new[gi] = request_seq[gi] & (2'(gi) < arrive_floor);
    end
  endgenerate

  logic here_cur, here_new;
  assign here_cur = request_seq[floor_reg];
  assign here_new = request_seq[arrive_floor];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      floor_reg  <= 2'd0;
      opnd_reg   <= 1'b0;
      moving_reg <= 1'b0;
      dir_reg    <= 1'b1;
      arrive_reg <= 1'b0;
      tick_reg   <= '0;
      door_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      floor_reg  <= floor_next;
      opnd_reg   <= opnd_next;
      moving_reg <= moving_next;
      dir_reg    <= dir_next;
      arrive_reg <= arrive_next;
      tick_reg   <= tick_next;
      door_reg   <= door_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    floor_next  = floor_reg;
    opnd_next   = opnd_reg;
    moving_next = moving_reg;
    dir_next    = dir_reg;
    arrive_next = 1'b0;
    tick_next   = tick_reg;
    door_next   = door_reg;

    case (state_reg)
      IDLE: begin
        tick_next = '0;
        door_next = '0;
        if (here_cur) begin
          state_next = DOOR_OPEN;
          opnd_next  = 1'b1;
        end else if ((|above_cur) && (|below_cur)) begin
          // Work on both sides: keep sweeping the way we were going.
          state_next  = dir_reg ? MOVE_UP : MOVE_DOWN;
          moving_next = 1'b1;
        end else if (|above_cur) begin
          state_next  = MOVE_UP;
          moving_next = 1'b1;
          dir_next    = 1'b1;
        end else if (|below_cur) begin
          state_next  = MOVE_DOWN;
          moving_next = 1'b1;
          dir_next    = 1'b0;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (tick_reg == FLOOR_LAST) begin
          tick_next   = '0;
          floor_next  = arrive_floor;
          arrive_next = 1'b1;
          if (here_new) begin
            state_next  = DOOR_OPEN;
            opnd_next   = 1'b1;
            moving_next = 1'b0;
          end else if ((state_reg == MOVE_UP) ? (|above_new) : (|below_new)) begin
            state_next = state_reg;
          end else begin
            // Nothing further this way; a reversal goes through IDLE.
            state_next  = IDLE;
            moving_next = 1'b0;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end

      DOOR_OPEN: begin
        if (door_reg == DOOR_LAST) begin
          door_next  = '0;
          state_next = IDLE;
          opnd_next  = 1'b0;
        end else begin
          door_next = door_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign current_floor = floor_reg;
  assign opnd          = opnd_reg;
  assign moving        = moving_reg;
  assign dir_up        = dir_reg;
  assign arrive        = arrive_reg;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Testbench for elevator_car_controller (FLOOR_TICKS=4, DOOR_TICKS=3).
// A table of hand-derived vectors, hand-written multi-cycle sequences, and a
// randomized run, all checked cycle by cycle.
module tb_elevator_car_controller;

  localparam int FT = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] request_seq = 4'b0000;
  logic [1:0] current_floor;
  logic       opnd, moving, dir_up, arrive;

  int tests_run    = 0;
  int tests_failed = 0;

  elevator_car_controller #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk          (clk),
    .rst          (rst),
    .request_seq  (request_seq),
    .current_floor(current_floor),
    .opnd         (opnd),
    .moving       (moving),
    .dir_up       (dir_up),
    .arrive       (arrive)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The car is described by what it is doing and how many cycles of that
  // activity remain.
  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  int m_mode, m_floor, m_left;
  bit m_dir, m_arrive;

  function automatic bit has_above(input logic [3:0] r, input int f);
    for (int i = f + 1; i < 4; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit has_below(input logic [3:0] r, input int f);
    for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_left = 0; m_dir = 1'b1; m_arrive = 1'b0;
  endtask

  task automatic model_go(input bit up);
    m_mode = up ? M_UP : M_DOWN;
    m_dir  = up;
    m_left = FT;
  endtask

  task automatic model_step(input logic [3:0] r);
    m_arrive = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (r[m_floor]) begin
          m_mode = M_DOOR; m_left = DT;
        end else if (has_above(r, m_floor) && has_below(r, m_floor)) model_go(m_dir);
        else if (has_above(r, m_floor)) model_go(1'b1);
        else if (has_below(r, m_floor)) model_go(1'b0);
      end
      M_UP, M_DOWN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor  = m_floor + ((m_mode == M_UP) ? 1 : -1);
          m_arrive = 1'b1;
          if (r[m_floor]) begin
            m_mode = M_DOOR; m_left = DT;
          end else if ((m_mode == M_UP) ? has_above(r, m_floor) : has_below(r, m_floor)) begin
            m_left = FT;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " floor"},  int'(current_floor), m_floor);
    check({tag, " opnd"},   int'(opnd),   int'(m_mode == M_DOOR));
    check({tag, " moving"}, int'(moving), int'(m_mode == M_UP || m_mode == M_DOWN));
    check({tag, " dir_up"}, int'(dir_up), int'(m_dir));
    check({tag, " arrive"}, int'(arrive), int'(m_arrive));
  endtask

  // One clock edge: model follows the same sampled requests; outputs are
  // inspected 1 time unit after the edge. auto_clear plays the request
  // latch, dropping the current-floor bit while the door is open.
  task automatic step(input bit auto_clear, input bit do_check, input string tag);
    @(posedge clk);
    model_step(request_seq);
    #1;
    if (do_check) check_model(tag);
    if (auto_clear && m_mode == M_DOOR) request_seq[m_floor] = 1'b0;
  endtask

  task automatic run_until_door(input string tag, input int max, output int fl);
    fl = -1;
    for (int i = 0; i < max; i++) begin
      step(1'b1, 1'b1, tag);
      if (opnd) begin
        fl = int'(current_floor);
        break;
      end
    end
    if (fl < 0) begin
      tests_run++; tests_failed++;
      $display("FAIL %s timeout: got no door open, expected one within %0d cycles", tag, max);
    end
  endtask

  task automatic wait_close(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (!opnd) break;
      step(1'b1, 1'b1, tag);
    end
    if (opnd) begin
      tests_run++; tests_failed++;
      $display("FAIL %s timeout: got door still open, expected closed within %0d cycles", tag, max);
    end
  endtask

  task automatic run_until_floor(input string tag, input int target, input int max);
    for (int i = 0; i < max; i++) begin
      if (int'(current_floor) == target) break;
      step(1'b1, 1'b1, tag);
    end
    check({tag, " reached"}, int'(current_floor), target);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;
    int         reps;
    int         floor;
    bit         opnd;
    bit         moving;
    bit         dir_up;
    bit         arrive;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int fl, arr_cnt, open_cnt;
    logic [3:0] prev_req;

    // Up from 0 to 3, door, then back down to 0, then a same-floor call.
    vecs.push_back(vec_t'{4'b1000, 4, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1000, 1, 1, 1'b0, 1'b1, 1'b1, 1'b1});
    vecs.push_back(vec_t'{4'b1000, 3, 1, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1000, 1, 2, 1'b0, 1'b1, 1'b1, 1'b1});
    vecs.push_back(vec_t'{4'b1000, 3, 2, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1000, 1, 3, 1'b1, 1'b0, 1'b1, 1'b1});
    vecs.push_back(vec_t'{4'b0000, 2, 3, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0000, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0001, 4, 3, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0001, 1, 2, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{4'b0001, 3, 2, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0001, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{4'b0001, 3, 1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0001, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{4'b0000, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0001, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0000, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset state
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset floor",  int'(current_floor), 0);
    check("reset opnd",   int'(opnd),   0);
    check("reset moving", int'(moving), 0);
    check("reset dir_up", int'(dir_up), 1);
    check("reset arrive", int'(arrive), 0);
    rst = 1'b1;
    model_reset();
    $display("[TB] reset released");

    // Table phase
    foreach (vecs[k]) begin
      request_seq = vecs[k].req;
      for (int r = 0; r < vecs[k].reps; r++) begin
        step(1'b0, 1'b0, "vec");
        check($sformatf("vec%0d.%0d floor", k, r),  int'(current_floor), vecs[k].floor);
        check($sformatf("vec%0d.%0d opnd", k, r),   int'(opnd),   int'(vecs[k].opnd));
        check($sformatf("vec%0d.%0d moving", k, r), int'(moving), int'(vecs[k].moving));
        check($sformatf("vec%0d.%0d dir_up", k, r), int'(dir_up), int'(vecs[k].dir_up));
        check($sformatf("vec%0d.%0d arrive", k, r), int'(arrive), int'(vecs[k].arrive));
      end
      $display("[TB] vec %0d req=%b reps=%0d floor=%0d opnd=%0b moving=%0b", k,
               vecs[k].req, vecs[k].reps, current_floor, opnd, moving);
    end

    // SCAN: idle at 1 heading up, calls at 0 and 3 -> 3 first, then 0
    request_seq = 4'b0010;
    run_until_door("scan_setup", 20, fl);
    check("scan_setup door floor", fl, 1);
    wait_close("scan_setup", 10);
    check("scan dir before", int'(dir_up), 1);
    request_seq = 4'b1001;
    run_until_door("scan_first", 40, fl);
    check("scan first door floor", fl, 3);
    wait_close("scan_first", 10);
    check("scan idle gap moving", int'(moving), 0);
    step(1'b1, 1'b1, "scan_rev");
    check("scan reverse moving", int'(moving), 1);
    check("scan reverse dir_up", int'(dir_up), 0);
    run_until_door("scan_second", 40, fl);
    check("scan second door floor", fl, 0);
    wait_close("scan_second", 10);
    $display("[TB] seq scan done floor=%0d", current_floor);

    // Intermediate call picked up on the way up
    request_seq = 4'b1000;
    run_until_floor("mid_call", 1, 20);
    step(1'b1, 1'b1, "mid_call");
    request_seq[2] = 1'b1;
    run_until_door("mid_call_a", 20, fl);
    check("mid_call first door floor", fl, 2);
    wait_close("mid_call_a", 10);
    run_until_door("mid_call_b", 30, fl);
    check("mid_call second door floor", fl, 3);
    wait_close("mid_call_b", 10);
    $display("[TB] seq mid_call done floor=%0d", current_floor);

    // Asynchronous reset in the middle of a segment
    request_seq = 4'b0001;
    run_until_door("areset_setup", 40, fl);
    check("areset_setup door floor", fl, 0);
    wait_close("areset_setup", 10);
    request_seq = 4'b1000;
    run_until_floor("areset_run", 2, 40);
    step(1'b1, 1'b1, "areset_run");
    step(1'b1, 1'b1, "areset_run");
    #2 rst = 1'b0;
    #1;
    check("areset floor",  int'(current_floor), 0);
    check("areset opnd",   int'(opnd),   0);
    check("areset moving", int'(moving), 0);
    check("areset dir_up", int'(dir_up), 1);
    check("areset arrive", int'(arrive), 0);
    model_reset();
    request_seq = 4'b0000;
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "areset_idle");
    $display("[TB] seq async reset done floor=%0d", current_floor);

    // Only request withdrawn mid-segment: finish the floor, no door
    request_seq = 4'b0010;
    run_until_door("vanish_setup", 20, fl);
    check("vanish_setup door floor", fl, 1);
    wait_close("vanish_setup", 10);
    request_seq = 4'b0100;
    step(1'b1, 1'b1, "vanish");
    step(1'b1, 1'b1, "vanish");
    request_seq = 4'b0000;
    arr_cnt = 0;
    open_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, "vanish");
      arr_cnt += int'(arrive);
      open_cnt += int'(opnd);
    end
    check("vanish arrive pulses", arr_cnt, 1);
    check("vanish door cycles", open_cnt, 0);
    check("vanish final floor", int'(current_floor), 2);
    check("vanish final moving", int'(moving), 0);
    $display("[TB] seq vanish done floor=%0d", current_floor);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      prev_req = request_seq;
      if ($urandom_range(0, 7) == 0) request_seq[$urandom_range(0, 3)] = 1'b1;
      if ($urandom_range(0, 63) == 0) request_seq[$urandom_range(0, 3)] = 1'b0;
      if (request_seq != prev_req)
        $display("[TB] rand cycle %0d req=%b floor=%0d", i, request_seq, current_floor);
      step(1'b1, 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
